// File: rtl/exc_commit.sv
// exc_commit: precise-exception commit stage arbitrating interrupt, exceptions and ERET toward cp0 and fetch
module exc_commit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic        in_bd,
    input  logic        in_adel_if,
    input  logic        in_ri,
    input  logic        in_ov,
    input  logic        in_sys,
    input  logic        in_bp,
    input  logic        in_adel_ld,
    input  logic        in_ades,
    input  logic        in_eret,
    input  logic [31:0] in_daddr,
    input  logic        cp0_has_int,
    input  logic [31:0] cp0_epc,
    output logic        w_cp0_update_ena,
    output logic [4:0]  w_cp0_exccode,
    output logic        w_cp0_bd,
    output logic        w_cp0_exl,
    output logic [31:0] w_cp0_epc,
    output logic        w_cp0_badvaddr_ena,
    output logic [31:0] w_cp0_badvaddr,
    output logic        cp0_cls_exl,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t      state;
    logic        acc;
    logic        exc;
    logic        eret;
    logic        bva;
    logic        mid;
    logic [4:0]  code;
    logic [31:0] bv;
    logic [31:0] epc;

    assign in_ready = (state == IDLE);
    assign acc      = in_valid && in_ready;

    // fixed-priority decode of the retiring instruction's events
    always_comb begin
        mid  = in_ri || in_ov || in_sys || in_bp;
        exc  = cp0_has_int || in_adel_if || mid || in_adel_ld || in_ades;
        eret = in_eret && !exc;
        code = cp0_has_int ? 5'h00 :
               in_adel_if  ? 5'h04 :
               in_ri       ? 5'h0A :
               in_ov       ? 5'h0C :
               in_sys      ? 5'h08 :
               in_bp       ? 5'h09 :
               in_adel_ld  ? 5'h04 : 5'h05;
        bva  = !cp0_has_int && (in_adel_if || (!mid && (in_adel_ld || in_ades)));
        bv   = in_adel_if ? in_pc : in_daddr;
        epc  = in_bd ? in_pc - 32'd4 : in_pc;
    end

    // commit FSM with registered cp0 writes, flush pulse and held redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            w_cp0_update_ena   <= 1'b0;
            w_cp0_exccode      <= 5'h00;
            w_cp0_bd           <= 1'b0;
            w_cp0_exl          <= 1'b0;
            w_cp0_epc          <= 32'h0;
            w_cp0_badvaddr_ena <= 1'b0;
            w_cp0_badvaddr     <= 32'h0;
            cp0_cls_exl        <= 1'b0;
            flush              <= 1'b0;
            redirect_valid     <= 1'b0;
            redirect_pc        <= 32'h0;
        end else begin
            w_cp0_update_ena   <= 1'b0;
            w_cp0_badvaddr_ena <= 1'b0;
            cp0_cls_exl        <= 1'b0;
            flush              <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc && exc) begin
                        state              <= REDIRECT;
                        w_cp0_update_ena   <= 1'b1;
                        w_cp0_exccode      <= code;
                        w_cp0_bd           <= in_bd;
                        w_cp0_exl          <= 1'b1;
                        w_cp0_epc          <= epc;
                        w_cp0_badvaddr_ena <= bva;
                        flush              <= 1'b1;
                        redirect_valid     <= 1'b1;
                        redirect_pc        <= EXC_VECTOR;
                        if (bva) w_cp0_badvaddr <= bv;
                    end else if (acc && eret) begin
                        state          <= REDIRECT;
                        cp0_cls_exl    <= 1'b1;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= cp0_epc;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/exc_commit.md
# exc_commit

Precise-exception commit stage between the memory stage and `cp0`. It accepts one retiring instruction per handshake together with its exception flags, and arbitrates interrupt, synchronous exceptions and ERET by fixed priority. It then issues a single-cycle CP0 update (`w_cp0_*` fields), a pipeline flush pulse and a held redirect request toward fetch, stalling further commits until fetch accepts the redirect.

## Interface
Parameters:
- `EXC_VECTOR`, 32'hBFC0_0380: redirect target for every exception and interrupt.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  retiring instruction present.
- `in_ready`  out  1  commit can accept; equals (state == IDLE).
- `in_pc`  in  32  PC of retiring instruction.
- `in_bd`  in  1  instruction is in a branch delay slot.
- `in_adel_if`  in  1  fetch address error.
- `in_ri`  in  1  reserved instruction.
- `in_ov`  in  1  arithmetic overflow.
- `in_sys`  in  1  syscall.
- `in_bp`  in  1  break.
- `in_adel_ld`  in  1  load address error.
- `in_ades`  in  1  store address error.
- `in_eret`  in  1  ERET.
- `in_daddr`  in  32  data address for load/store faults.
- `cp0_has_int`  in  1  pending enabled interrupt from `cp0`.
- `cp0_epc`  in  32  current EPC from `cp0`.
- `w_cp0_update_ena`  out  1  one-cycle CP0 exception write.
- `w_cp0_exccode`  out  5  ExcCode.
- `w_cp0_bd`  out  1  Cause.BD value.
- `w_cp0_exl`  out  1  Status.EXL value; always 1 when update is asserted.
- `w_cp0_epc`  out  32  EPC value.
- `w_cp0_badvaddr_ena`  out  1  BadVAddr write qualifier.
- `w_cp0_badvaddr`  out  32  BadVAddr value.
- `cp0_cls_exl`  out  1  one-cycle EXL clear for ERET.
- `flush`  out  1  one-cycle pipeline flush.
- `redirect_valid`  out  1  redirect request to fetch.
- `redirect_pc`  out  32  redirect target.
- `redirect_ready`  in  1  fetch accepts the redirect.

## Operation
- Accept occurs when `in_valid && in_ready`. Only an accepted instruction is arbitrated. All flags are ignored when there is no accept.
- Priority, highest first:
  - interrupt (`cp0_has_int` sampled at accept), code 0x00
  - `in_adel_if`, code 0x04, BadVAddr = `in_pc`
  - `in_ri`, code 0x0A
  - `in_ov`, code 0x0C
  - `in_sys`, code 0x08
  - `in_bp`, code 0x09
  - `in_adel_ld`, code 0x04, BadVAddr = `in_daddr`
  - `in_ades`, code 0x05, BadVAddr = `in_daddr`
  - `in_eret`
- Exception (first 8 items):
  - EPC = `in_bd` ? `in_pc`-4 : `in_pc`, computed mod 2^32.
  - BD = `in_bd`; EXL = 1.
  - `w_cp0_badvaddr_ena` = 1 only for the three address-error cases.
  - Target = `EXC_VECTOR`.
- ERET with no higher-priority event:
  - `cp0_cls_exl` pulses; no `w_cp0_update_ena`.
  - Target = `cp0_epc` sampled at accept.
- Both the exception and ERET cases pulse `flush` and enter REDIRECT.
- Accepted instruction with no flags and no interrupt: no outputs change; state stays IDLE.
- An interrupt pending with no accept is not taken; it is taken on the next accepted instruction.
- FSM:
  - IDLE -> REDIRECT on an accept that produces an exception or ERET.
  - REDIRECT -> IDLE when `redirect_valid && redirect_ready`.
- In REDIRECT: `in_ready` = 0; `redirect_valid` = 1; `redirect_pc` stays stable.

## Timing
- Accept in cycle t: `w_cp0_*`, `cp0_cls_exl` and `flush` are registered and high during t+1 only.
- `redirect_valid` rises at t+1 and stays high through the handshake cycle.
- If `redirect_ready` is high at t+1, state returns to IDLE and `in_ready` is 1 at t+2. Earliest back-to-back accept is therefore t+2.
- `w_cp0_*` data fields hold their last value when not qualified.
- Reset values, for all outputs:
  - `w_cp0_update_ena`, `w_cp0_badvaddr_ena`, `cp0_cls_exl`, `flush`, `redirect_valid` = 0.
  - Data fields = 0; state = IDLE, so `in_ready` = 1.
- Reset asserted in REDIRECT (or during a pulse) clears immediately and asynchronously. No redirect resumes after release.
- `redirect_ready` while in IDLE is ignored.

## Test plan
- Syscall accepted, `in_pc`=0xBFC0_1000, `in_bd`=0, `redirect_ready`=1 -> t+1: update=1, exccode=0x08, epc=0xBFC0_1000, badvaddr_ena=0, flush=1, redirect_pc=0xBFC0_0380; `in_ready`=1 at t+2.
- Load AdEL in delay slot, `in_pc`=0x8000_0104, `in_daddr`=0x8000_2001 -> exccode=0x04, bd=1, epc=0x8000_0100, badvaddr=0x8000_2001.
- `cp0_has_int`=1 together with `in_ov`=1 and `in_eret`=1 -> only exccode=0x00 is taken, `cp0_cls_exl`=0.
- `in_pc`=0x0000_0000 with `in_bd`=1 and `in_sys`=1 -> epc=0xFFFF_FFFC.
- ERET with `cp0_epc`=0xBFC0_2000, `redirect_ready` held low 3 cycles -> `cp0_cls_exl` pulses once, `redirect_valid` stays high 4 cycles with pc stable, `in_ready`=0 throughout.
- Reset asserted mid-REDIRECT -> `redirect_valid`=0 immediately; after release, `in_ready`=1 and no spurious pulses.
